// File: rtl/pll_lock_rst_seq.sv
// PLL lock supervisor: sequences the PLL areset, qualifies a stable lock and
// produces the reset for PLL-clocked logic; retries on lock timeout, counts lock losses.
module pll_lock_rst_seq #(
  parameter int ARESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1_000_000,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_areset,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] loss_cnt,
  output logic       timeout_err,
  output logic [2:0] state
);

  localparam int MAX_AB  = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_SH  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_SH) ? MAX_AB : MAX_SH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RET_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  logic             sync1_q, sync2_q;
  logic             locked_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             err_q, err_d;
  logic             pll_areset_q, pll_areset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;

  assign locked_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    retry_d      = retry_q;
    loss_d       = loss_q;
    err_d        = err_q;
    pll_areset_d = pll_areset_q;
    sys_rst_d    = sys_rst_q;
    ready_d      = ready_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
          state_d      = WAIT_LOCK;
          cnt_d        = '0;
          pll_areset_d = 1'b0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d      = PLL_RST;
          cnt_d        = '0;
          pll_areset_d = 1'b1;
          if (retry_q != RET_W'(MAX_RETRY)) retry_d = retry_q + RET_W'(1);
          if (retry_d == RET_W'(MAX_RETRY)) err_d = 1'b1;
        end
      end
      STABLE: begin
        // A dropout here is still lock acquisition, not a loss.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d   = RUN;
          cnt_d     = '0;
          retry_d   = '0;
          sys_rst_d = 1'b0;
          ready_d   = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          sys_rst_d = 1'b1;
          ready_d   = 1'b0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: begin
        state_d      = PLL_RST;
        cnt_d        = '0;
        pll_areset_d = 1'b1;
        sys_rst_d    = 1'b1;
        ready_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      err_q        <= 1'b0;
      pll_areset_q <= 1'b1;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      sync1_q      <= locked_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      err_q        <= err_d;
      pll_areset_q <= pll_areset_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
    end
  end

  assign pll_areset  = pll_areset_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign loss_cnt    = loss_q;
  assign timeout_err = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: per-cycle expected outputs from a reference model go
// into a queue that a negedge monitor drains and compares; directed checks cover the key timings.
module tb_pll_lock_rst_seq;
  localparam int P_ARESET    = 4;
  localparam int P_TIMEOUT   = 20;
  localparam int P_STABLE    = 8;
  localparam int P_HOLD      = 4;
  localparam int P_MAX_RETRY = 2;
  localparam int W           = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked_in;
  logic       pll_areset, sys_rst, ready, timeout_err;
  logic [7:0] loss_cnt;
  logic [2:0] state;
  logic [W-1:0] dut_vec;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: state code matching the DUT encoding, time spent in it, counters
  int m_state, m_t, m_retry, m_loss;
  bit m_err;
  bit m_sync[$];

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .ARESET_CYCLES(P_ARESET), .LOCK_TIMEOUT(P_TIMEOUT), .STABLE_CYCLES(P_STABLE),
    .HOLD_CYCLES(P_HOLD), .MAX_RETRY(P_MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .locked_in(locked_in), .pll_areset(pll_areset),
    .sys_rst(sys_rst), .ready(ready), .loss_cnt(loss_cnt),
    .timeout_err(timeout_err), .state(state)
  );

  assign dut_vec = {state, pll_areset, sys_rst, ready, loss_cnt, timeout_err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_t = 0; m_retry = 0; m_loss = 0; m_err = 1'b0;
    m_sync = '{1'b0, 1'b0};
  endfunction

  function automatic void go(input int s);
    m_state = s;
    m_t = 0;
  endfunction

  // One clock edge: FSM sees the lock value from two edges ago.
  function automatic void model_step(input bit lk);
    bit ls;
    ls = m_sync.pop_front();
    m_sync.push_back(lk);
    m_t++;
    case (m_state)
      0: if (m_t == P_ARESET) go(1);
      1: begin
        if (ls) go(2);
        else if (m_t == P_TIMEOUT) begin
          go(0);
          if (m_retry < P_MAX_RETRY) m_retry++;
          if (m_retry == P_MAX_RETRY) m_err = 1'b1;
        end
      end
      2: if (!ls) go(1); else if (m_t == P_STABLE) go(3);
      3: begin
        if (!ls) begin go(1); if (m_loss < 255) m_loss++; end
        else if (m_t == P_HOLD) begin go(4); m_retry = 0; end
      end
      default: if (!ls) begin go(1); if (m_loss < 255) m_loss++; end
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [2:0] st;
    logic [7:0] lc;
    st = m_state[2:0];
    lc = m_loss[7:0];
    return {st, m_state == 0, m_state != 4, m_state == 4, lc, m_err};
  endfunction

  // Drive the input for the coming edge, then record what the DUT must show after it.
  task automatic tick(input logic lk);
    locked_in = lk;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(lk);
    exp_q.push_back(model_vec());
    #1;
  endtask

  task automatic run_until(input logic lk, input int target, input int bound, input string name);
    int n;
    n = 0;
    while (m_state != target && n < bound) begin
      tick(lk);
      n++;
    end
    check(name, state, target);
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", dut_vec, e);
      end
    end
  end

  initial begin : driver
    logic [W-1:0] rst_vec;
    int len;
    logic val;
    rst_vec = {3'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    rst = 1'b1;
    locked_in = 1'b1;
    model_reset();
    repeat (3) tick(1'b1);
    check("reset_vec", dut_vec, rst_vec);
    rst = 1'b0;

    // basic lock: areset 4 cycles, ready on edge 17
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1);
      check($sformatf("t1_areset_e%0d", k), pll_areset, k < 4);
      check($sformatf("t1_sys_rst_e%0d", k), sys_rst, k < 17);
      check($sformatf("t1_ready_e%0d", k), ready, k >= 17);
    end
    check("t1_loss", loss_cnt, 0);
    check("t1_err", timeout_err, 0);

    // loss in RUN: sys_rst rises 3 edges after the drop
    tick(1'b0); check("t4_sys_rst_e1", sys_rst, 0);
    tick(1'b0); check("t4_sys_rst_e2", sys_rst, 0);
    tick(1'b0); check("t4_sys_rst_e3", sys_rst, 1);
    check("t4_state", state, 1);
    check("t4_loss", loss_cnt, 1);
    for (int k = 1; k <= 15; k++) begin
      tick(1'b1);
      check($sformatf("t4_relock_e%0d", k), ready, k == 15);
    end

    // glitch during STABLE
    repeat (3) tick(1'b0);
    run_until(1'b1, 2, 10, "t3_reach_stable");
    repeat (4) tick(1'b1);
    repeat (3) tick(1'b0);
    check("t3_back_to_wait", state, 1);
    run_until(1'b1, 4, 40, "t3_reach_run");
    check("t3_loss", loss_cnt, 2);

    // timeout and retry
    for (int k = 1; k <= 47; k++) begin
      tick(1'b0);
      if (k == 24) begin
        check("t2_first_retry_state", state, 0);
        check("t2_err_after_1", timeout_err, 0);
      end
    end
    check("t2_second_retry_state", state, 0);
    check("t2_err_after_2", timeout_err, 1);
    repeat (30) tick(1'b0);
    run_until(1'b1, 4, 60, "t2_reach_run");
    check("t2_err_sticky", timeout_err, 1);

    // random lock patterns
    for (int r = 0; r < 25; r++) begin
      val = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 25);
      repeat (len) tick(val);
    end

    // loss counter saturation
    for (int r = 0; r < 260; r++) begin
      run_until(1'b1, 4, 60, "t5_reach_run");
      repeat (3) tick(1'b0);
    end
    check("t5_loss_sat", loss_cnt, 255);

    // async reset in HOLD, between edges
    run_until(1'b1, 3, 60, "t6_reach_hold");
    tick(1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_reset_vec", dut_vec, rst_vec);
    repeat (2) tick(1'b1);
    rst = 1'b0;
    run_until(1'b1, 4, 40, "t6_reach_run");

    @(negedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
